// File: rtl/pc_control_sequencer.sv
// Controller-sequencer for the 8-bit CPU: one-hot T1-T6 ring, fetch then opcode-dependent execute.
// Strobes decode combinationally from the registered T-state; ring advances every clock, no backpressure.
module pc_control_sequencer #(
  parameter bit SHORT_CYCLE = 1'b0,
  parameter int OPCODE_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [5:0]          t_state,
  output logic                pc_en,
  output logic                pc_oe,
  output logic                pc_ld,
  output logic                mar_ld,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                ir_ld,
  output logic                ir_oe,
  output logic                a_ld,
  output logic                a_oe,
  output logic                b_ld,
  output logic                alu_oe,
  output logic                alu_sub,
  output logic                out_ld,
  output logic                hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  t_state_e ring_q, ring_d;
  logic     halted_q, halted_d;
  logic     last_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    {pc_en, pc_oe, pc_ld, mar_ld, ram_oe, ram_we, ir_ld,
     ir_oe, a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld} = '0;
    ring_d    = ring_q;
    halted_d  = halted_q;
    last_step = 1'b0;

    // Reset and halt both gate every strobe; the ring only moves when neither holds.
    if (!rst && !halted_q) begin
      case (ring_q)
        T1: begin pc_oe = 1'b1; mar_ld = 1'b1; end
        T2: pc_en = 1'b1;
        T3: begin ram_oe = 1'b1; ir_ld = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_oe = 1'b1; mar_ld = 1'b1; end
            OP_JMP: begin ir_oe = 1'b1; pc_ld = 1'b1; last_step = 1'b1; end
            OP_OUT: begin a_oe = 1'b1; out_ld = 1'b1; last_step = 1'b1; end
            OP_HLT: halted_d = 1'b1;
            default: last_step = 1'b1;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin ram_oe = 1'b1; a_ld = 1'b1; last_step = 1'b1; end
            OP_ADD, OP_SUB: begin ram_oe = 1'b1; b_ld = 1'b1; end
            OP_STA: begin a_oe = 1'b1; ram_we = 1'b1; last_step = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          last_step = 1'b1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe  = 1'b1;
            a_ld    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase

      if (halted_d)
        ring_d = ring_q;
      else if (SHORT_CYCLE && last_step)
        ring_d = T1;
      else
        ring_d = t_state_e'({ring_q[4:0], ring_q[5]});
    end
  end

  assign t_state = ring_q;
  assign hlt     = halted_q;

  a_bus_onehot: assert property (@(posedge clk) $onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}));
  a_ring_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(ring_q));
  a_pc_excl: assert property (@(posedge clk) !(pc_en && pc_ld));

endmodule

// File: tb/tb_pc_control_sequencer.sv
// Bench for pc_control_sequencer: one instance per SHORT_CYCLE value, cycle scoreboard from the instruction table.
module tb_pc_control_sequencer;

  localparam int PC_EN = 13, PC_OE = 12, PC_LD = 11, MAR_LD = 10, RAM_OE = 9, RAM_WE = 8;
  localparam int IR_LD = 7, IR_OE = 6, A_LD = 5, A_OE = 4, B_LD = 3, ALU_OE = 2;
  localparam int ALU_SUB = 1, OUT_LD = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  wire  [5:0]  ts  [2];
  wire  [13:0] stb [2];
  wire         hl  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pc_control_sequencer #(.SHORT_CYCLE(g == 1), .OPCODE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .t_state(ts[g]),
      .pc_en(stb[g][PC_EN]), .pc_oe(stb[g][PC_OE]), .pc_ld(stb[g][PC_LD]),
      .mar_ld(stb[g][MAR_LD]), .ram_oe(stb[g][RAM_OE]), .ram_we(stb[g][RAM_WE]),
      .ir_ld(stb[g][IR_LD]), .ir_oe(stb[g][IR_OE]), .a_ld(stb[g][A_LD]),
      .a_oe(stb[g][A_OE]), .b_ld(stb[g][B_LD]), .alu_oe(stb[g][ALU_OE]),
      .alu_sub(stb[g][ALU_SUB]), .out_ld(stb[g][OUT_LD]), .hlt(hl[g])
    );
  end

  typedef struct {
    int          dut;
    logic [5:0]  ts;
    logic [13:0] stb;
    logic        hlt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;
  int   mt[2];
  bit   mh[2];
  bit   mvalid[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe table for T-step t (1..6) of opcode op.
  function automatic logic [13:0] exp_strb(int t, logic [3:0] op);
    logic [13:0] s = '0;
    case (t)
      1: begin s[PC_OE] = 1'b1; s[MAR_LD] = 1'b1; end
      2: s[PC_EN] = 1'b1;
      3: begin s[RAM_OE] = 1'b1; s[IR_LD] = 1'b1; end
      4: begin
        if (op <= 4'h3) begin s[IR_OE] = 1'b1; s[MAR_LD] = 1'b1; end
        else if (op == 4'h4) begin s[IR_OE] = 1'b1; s[PC_LD] = 1'b1; end
        else if (op == 4'hE) begin s[A_OE] = 1'b1; s[OUT_LD] = 1'b1; end
      end
      5: begin
        if (op == 4'h0) begin s[RAM_OE] = 1'b1; s[A_LD] = 1'b1; end
        else if (op == 4'h1 || op == 4'h2) begin s[RAM_OE] = 1'b1; s[B_LD] = 1'b1; end
        else if (op == 4'h3) begin s[A_OE] = 1'b1; s[RAM_WE] = 1'b1; end
      end
      6: begin
        if (op == 4'h1 || op == 4'h2) begin
          s[ALU_OE]  = 1'b1;
          s[A_LD]    = 1'b1;
          s[ALU_SUB] = (op == 4'h2);
        end
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic bit short_last(int t, logic [3:0] op);
    if (op == 4'h0 || op == 4'h3) return t == 5;
    if (op == 4'h1 || op == 4'h2) return t == 6;
    if (op == 4'hF) return 1'b0;
    return t == 4;
  endfunction

  // One clock: drive inputs at negedge, push expectations, compare, then step the model.
  task automatic cyc(input logic r, input logic [3:0] op);
    @(negedge clk);
    rst    = r;
    opcode = op;
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.dut = d;
      e.ts  = 6'b000001 << (mt[d] - 1);
      e.hlt = mh[d];
      e.stb = (r || mh[d]) ? 14'h0 : exp_strb(mt[d], op);
      sbq.push_back(e);
    end
    #1;
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      if (mvalid[e.dut]) begin
        check($sformatf("c%0d d%0d t_state", cyc_n, e.dut), 32'(ts[e.dut]), 32'(e.ts));
        check($sformatf("c%0d d%0d hlt", cyc_n, e.dut), 32'(hl[e.dut]), 32'(e.hlt));
      end
      check($sformatf("c%0d d%0d strobes", cyc_n, e.dut), 32'(stb[e.dut]), 32'(e.stb));
      check($sformatf("c%0d d%0d bus_onehot0", cyc_n, e.dut),
            32'($onehot0({stb[e.dut][PC_OE], stb[e.dut][RAM_OE], stb[e.dut][IR_OE],
                          stb[e.dut][A_OE], stb[e.dut][ALU_OE]})), 32'(1));
    end
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        mt[d] = 1; mh[d] = 1'b0; mvalid[d] = 1'b1;
      end else if (mh[d]) begin
        mt[d] = mt[d];
      end else if (mt[d] == 4 && op == 4'hF) begin
        mh[d] = 1'b1;
      end else if (d == 1 && short_last(mt[d], op)) begin
        mt[d] = 1;
      end else begin
        mt[d] = (mt[d] == 6) ? 1 : mt[d] + 1;
      end
    end
    cyc_n++;
  endtask

  task automatic run(input logic [3:0] op, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, op);
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 4'h0;
    mt     = '{1, 1};
    mh     = '{1'b0, 1'b0};
    mvalid = '{1'b0, 1'b0};

    // Reset for two clocks, then fetch of LDA with literal T-state checks.
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b0, 4'h0); check("fetch_t1", 32'(ts[0]), 32'(6'b000001));
    cyc(1'b0, 4'h0); check("fetch_t2", 32'(ts[0]), 32'(6'b000010));
    cyc(1'b0, 4'h0); check("fetch_t3", 32'(ts[0]), 32'(6'b000100));
    run(4'h0, 3);

    // ADD then SUB back to back.
    cyc(1'b1, 4'h0);
    run(4'h1, 6); check("add_t6_sub", 32'(stb[0][ALU_SUB]), 32'(0));
    run(4'h2, 6); check("sub_t6_sub", 32'(stb[0][ALU_SUB]), 32'(1));
    cyc(1'b0, 4'h2); check("after_sub_t1", 32'(ts[1]), 32'(6'b000001));

    // JMP: long form on instance 0, short form on instance 1.
    cyc(1'b1, 4'h0);
    run(4'h4, 4);
    check("jmp_t4_pc_en", 32'(stb[0][PC_EN]), 32'(0));
    check("jmp_t4_sc1", 32'(ts[1]), 32'(6'b001000));
    cyc(1'b0, 4'h4);
    check("jmp_t5_sc0", 32'(ts[0]), 32'(6'b010000));
    check("jmp_wrap_sc1", 32'(ts[1]), 32'(6'b000001));
    cyc(1'b0, 4'h4); check("jmp_t6_sc0", 32'(ts[0]), 32'(6'b100000));
    cyc(1'b0, 4'h4); check("jmp_wrap_sc0", 32'(ts[0]), 32'(6'b000001));

    // HLT holds T4 with no strobes until reset.
    cyc(1'b1, 4'h0);
    run(4'hF, 4);
    run(4'hF, 10);
    check("hlt_flag", 32'(hl[0]), 32'(1));
    check("hlt_ts", 32'(ts[0]), 32'(6'b001000));
    cyc(1'b1, 4'hF);
    cyc(1'b0, 4'h0);
    check("hlt_clr", 32'(hl[0]), 32'(0));
    check("hlt_clr_ts", 32'(ts[0]), 32'(6'b000001));

    // Reset during STA's write step.
    cyc(1'b1, 4'h0);
    run(4'h3, 4);
    cyc(1'b1, 4'h3);
    check("sta_rst_ts", 32'(ts[0]), 32'(6'b010000));
    check("sta_rst_we", 32'({stb[0][RAM_WE], stb[0][A_OE]}), 32'(0));
    cyc(1'b0, 4'h3); check("sta_rst_t1", 32'(ts[0]), 32'(6'b000001));

    // Unknown opcode, OUT, then every opcode through a full instruction.
    cyc(1'b1, 4'h0);
    run(4'h7, 6);
    cyc(1'b1, 4'h0);
    run(4'hE, 6);
    for (int op = 0; op < 16; op++) begin
      cyc(1'b1, 4'h0);
      run(4'(op), 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
